// File: rtl/pspin_hostmem_dma_rd_arb_if.sv
// AXI read-channel bundle (AR + R) used on both sides of the host-memory DMA
// read arbiter. NP lanes are flattened into vectors with lane 0 in the LSBs, so
// one definition serves the NUM_PORTS-wide requester side (NP=NUM_PORTS) and the
// single downstream port (NP=1).
//
// Parameters: NP lanes, AW address width, DW data width, IW ID width.
// Modports:
//   master - issues AR, consumes R (drives ar*, rready)
//   slave  - accepts AR, produces R (drives arready, r* except rready)
//
// Handshake semantics, both channels: a beat transfers on a rising clk edge
// where valid and ready are both high; once valid is raised, the payload stays
// stable and valid stays high until that transfer.
interface pspin_hostmem_dma_rd_arb_if #(
    parameter int NP = 1,
    parameter int AW = 64,
    parameter int DW = 512,
    parameter int IW = 6
);
    logic [NP*AW-1:0] araddr;
    logic [NP*IW-1:0] arid;
    logic [NP*8-1:0]  arlen;
    logic [NP*3-1:0]  arsize;
    logic [NP*2-1:0]  arburst;
    logic [NP-1:0]    arvalid;
    logic [NP-1:0]    arready;
    logic [NP*IW-1:0] rid;
    logic [NP*DW-1:0] rdata;
    logic [NP*2-1:0]  rresp;
    logic [NP-1:0]    rlast;
    logic [NP-1:0]    rvalid;
    logic [NP-1:0]    rready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/pspin_hostmem_dma_rd_arb.sv
// Round-robin arbiter sharing the single-transaction host-memory DMA read
// datapath among NUM_PORTS AXI read masters. One burst is in flight at a time:
// the winning AR is registered and replayed downstream, and the R beats are
// passed straight through to the owner until the final beat.
//
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   s_axi      - NUM_PORTS requester AR/R ports (slave side)
//   m_axi      - downstream AR/R port (master side); ID = {port, requester ID}
//   busy       - a burst is owned (ADDR or DATA)
//   grant_idx  - current or most recently granted port
//   proto_err  - sticky: rlast/beat-count mismatch or foreign R ID
//   state_dbg  - current FSM state encoding (IDLE=0, ADDR=1, DATA=2)
module pspin_hostmem_dma_rd_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int S_ID_WIDTH = 6,
    parameter int IDX_WIDTH  = $clog2(NUM_PORTS),
    parameter int M_ID_WIDTH = S_ID_WIDTH + IDX_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    pspin_hostmem_dma_rd_arb_if.slave  s_axi,
    pspin_hostmem_dma_rd_arb_if.master m_axi,
    output logic                      busy,
    output logic [IDX_WIDTH-1:0]      grant_idx,
    output logic                      proto_err,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [IDX_WIDTH-1:0]    rr_ptr;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [M_ID_WIDTH-1:0]   ar_id;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic [7:0]              beat_cnt;

    logic                    found;
    logic [IDX_WIDTH-1:0]    winner;
    logic [IDX_WIDTH-1:0]    cand;
    int                      p;
    logic                    ar_hs;
    logic                    r_hs;

    // Round-robin search starting at rr_ptr; the modulo keeps the walk in range
    // for port counts that are not a power of two.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        p      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p    = (int'(rr_ptr) + i) % NUM_PORTS;
            cand = p[IDX_WIDTH-1:0];
            if (!found && s_axi.arvalid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign ar_hs = (state == IDLE) && found;
    assign r_hs  = (state == DATA) && m_axi.rvalid[0] && m_axi.rready[0];

    always_comb begin
        state_d        = state;
        s_axi.arready  = '0;
        s_axi.rvalid   = '0;
        m_axi.arvalid  = 1'b0;
        m_axi.rready   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    s_axi.arready[winner] = 1'b1;
                    state_d               = ADDR;
                end
            end
            ADDR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready[0]) state_d = DATA;
            end
            DATA: begin
                s_axi.rvalid[grant_idx] = m_axi.rvalid[0];
                m_axi.rready            = s_axi.rready[grant_idx];
                // The burst ends on rlast even if the beat count disagrees.
                if (r_hs && m_axi.rlast[0]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // R payload is broadcast; only the owner's rvalid qualifies it.
    assign s_axi.rid   = {NUM_PORTS{m_axi.rid[S_ID_WIDTH-1:0]}};
    assign s_axi.rdata = {NUM_PORTS{m_axi.rdata}};
    assign s_axi.rresp = {NUM_PORTS{m_axi.rresp}};
    assign s_axi.rlast = {NUM_PORTS{m_axi.rlast[0]}};

    assign m_axi.araddr  = ar_addr;
    assign m_axi.arid    = ar_id;
    assign m_axi.arlen   = ar_len;
    assign m_axi.arsize  = ar_size;
    assign m_axi.arburst = ar_burst;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            ar_addr   <= '0;
            ar_id     <= '0;
            ar_len    <= '0;
            ar_size   <= '0;
            ar_burst  <= '0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_d;
            if (ar_hs) begin
                ar_addr   <= s_axi.araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                ar_id     <= {winner, s_axi.arid[winner*S_ID_WIDTH +: S_ID_WIDTH]};
                ar_len    <= s_axi.arlen[winner*8 +: 8];
                ar_size   <= s_axi.arsize[winner*3 +: 3];
                ar_burst  <= s_axi.arburst[winner*2 +: 2];
                beat_cnt  <= s_axi.arlen[winner*8 +: 8];
                grant_idx <= winner;
                if (winner == IDX_WIDTH'(NUM_PORTS - 1)) rr_ptr <= '0;
                else                                     rr_ptr <= winner + 1'b1;
            end
            if (r_hs) begin
                // beat_cnt holds the number of beats still expected after this one.
                if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
                if ((m_axi.rlast[0] && beat_cnt != 8'd0) ||
                    (!m_axi.rlast[0] && beat_cnt == 8'd0) ||
                    (m_axi.rid[M_ID_WIDTH-1:S_ID_WIDTH] != grant_idx))
                    proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pspin_hostmem_dma_rd_arb.sv
// Directed bench for pspin_hostmem_dma_rd_arb (4 ports, 64-bit address,
// 512-bit data, 6-bit requester IDs). Inputs change 1 ns after the rising edge,
// outputs are sampled 1 ns later.
module tb_pspin_hostmem_dma_rd_arb;
    localparam int NP  = 4;
    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int SIW = 6;
    localparam int IXW = 2;
    localparam int MIW = SIW + IXW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic           busy;
    logic [IXW-1:0] grant_idx;
    logic           proto_err;
    logic [1:0]     state_dbg;

    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] exp_q[$];

    pspin_hostmem_dma_rd_arb_if #(.NP(NP), .AW(AW), .DW(DW), .IW(SIW)) s_if ();
    pspin_hostmem_dma_rd_arb_if #(.NP(1),  .AW(AW), .DW(DW), .IW(MIW)) m_if ();

    pspin_hostmem_dma_rd_arb #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .S_ID_WIDTH(SIW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_axi    (s_if),
        .m_axi    (m_if),
        .busy     (busy),
        .grant_idx(grant_idx),
        .proto_err(proto_err),
        .state_dbg(state_dbg)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_if.araddr  = '0;
        s_if.arid    = '0;
        s_if.arlen   = '0;
        s_if.arsize  = '0;
        s_if.arburst = '0;
        s_if.arvalid = '0;
        s_if.rready  = '0;
        m_if.arready = '0;
        m_if.rid     = '0;
        m_if.rdata   = '0;
        m_if.rresp   = '0;
        m_if.rlast   = '0;
        m_if.rvalid  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    64'(busy), 64'd0);
        check({tag, "_grant"},   64'(grant_idx), 64'd0);
        check({tag, "_perr"},    64'(proto_err), 64'd0);
        check({tag, "_state"},   64'(state_dbg), 64'd0);
        check({tag, "_marv"},    64'(m_if.arvalid), 64'd0);
        check({tag, "_mrrdy"},   64'(m_if.rready), 64'd0);
        check({tag, "_srvalid"}, 64'(s_if.rvalid), 64'd0);
    endtask

    // One complete burst from a single requester. last_at is the beat index on
    // which the downstream raises rlast (arlen for a well-formed burst).
    task automatic do_burst(input int port, input logic [5:0] id, input logic [7:0] len,
                            input logic [63:0] addr, input int ar_stall, input logic [1:0] resp,
                            input int last_at, input int stall_beat, input int stall_cycles,
                            input logic exp_err);
        logic [MIW-1:0] exp_id;
        int beat;
        int got_beats;
        int budget;
        int stall_left;
        logic rr;
        exp_id     = {IXW'(port), id};
        beat       = 0;
        got_beats  = 0;
        budget     = 0;
        stall_left = stall_cycles;

        s_if.araddr[port*AW +: AW]  = addr;
        s_if.arid[port*SIW +: SIW]  = id;
        s_if.arlen[port*8 +: 8]     = len;
        s_if.arsize[port*3 +: 3]    = 3'd6;
        s_if.arburst[port*2 +: 2]   = 2'b01;
        s_if.arvalid[port]          = 1'b1;
        #1;
        check("ar_ready_onehot", 64'(s_if.arready), 64'(1 << port));
        check("m_arvalid_same_cycle", 64'(m_if.arvalid), 64'd0);
        tick();
        s_if.arvalid[port] = 1'b0;
        #1;
        check("m_arvalid", 64'(m_if.arvalid), 64'd1);
        check("m_arid", 64'(m_if.arid), 64'(exp_id));
        check("m_araddr", m_if.araddr, addr);
        check("m_arlen", 64'(m_if.arlen), 64'(len));
        check("m_arsize", 64'(m_if.arsize), 64'd6);
        check("grant_idx", 64'(grant_idx), 64'(port));
        check("busy_addr", 64'(busy), 64'd1);
        for (int i = 0; i < ar_stall; i++) begin
            tick();
            #1;
            check("ar_hold_valid", 64'(m_if.arvalid), 64'd1);
            check("ar_hold_addr", m_if.araddr, addr);
            check("ar_hold_len", 64'(m_if.arlen), 64'(len));
            check("ar_hold_id", 64'(m_if.arid), 64'(exp_id));
        end
        m_if.arready = 1'b1;
        tick();
        m_if.arready = 1'b0;

        for (int i = 0; i <= last_at; i++) exp_q.push_back(addr + 64'(i));
        while (beat <= last_at && budget < 60) begin
            rr = !(beat == stall_beat && stall_left > 0);
            if (!rr) stall_left--;
            s_if.rready       = '0;
            s_if.rready[port] = rr;
            m_if.rvalid       = 1'b1;
            m_if.rid          = exp_id;
            m_if.rdata        = DW'(addr + 64'(beat));
            m_if.rresp        = resp;
            m_if.rlast        = (beat == last_at);
            #1;
            check("r_valid_steer", 64'(s_if.rvalid), 64'(1 << port));
            check("m_rready", 64'(m_if.rready), 64'(rr));
            if (rr) begin
                check("r_data", s_if.rdata[port*DW +: 64], exp_q.pop_front());
                check("r_id", 64'(s_if.rid[port*SIW +: SIW]), 64'(id));
                check("r_resp", 64'(s_if.rresp[port*2 +: 2]), 64'(resp));
                check("r_last", 64'(s_if.rlast[port]), 64'(beat == last_at));
                beat++;
                got_beats++;
            end
            budget++;
            tick();
        end
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
        s_if.rready = '0;
        exp_q.delete();
        #1;
        check("r_beats", 64'(got_beats), 64'(last_at + 1));
        check("busy_after", 64'(busy), 64'd0);
        check("proto_err", 64'(proto_err), 64'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    int grants [NP];

    initial begin
        clear_inputs();
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("reset_arready", 64'(s_if.arready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // Single port, well-formed 4-beat burst.
        do_burst(2, 6'd5, 8'd3, 64'h1000_0040, 0, 2'b00, 3, -1, 0, 1'b0);
        // SLVERR passthrough on a 2-beat burst.
        do_burst(0, 6'd7, 8'd1, 64'h0000_2000, 0, 2'b10, 1, -1, 0, 1'b0);
        // AR back-pressure 5 cycles, R back-pressure 3 cycles on beat 1.
        do_burst(3, 6'h2a, 8'd3, 64'h3000_0100, 5, 2'b00, 3, 1, 3, 1'b0);
        // Early rlast on beat 2 of a 4-beat burst.
        do_burst(1, 6'd3, 8'd3, 64'h0000_4000, 0, 2'b00, 1, -1, 0, 1'b1);
        // Next request served normally, error stays sticky.
        do_burst(2, 6'd9, 8'd0, 64'h0000_5000, 0, 2'b00, 0, -1, 0, 1'b1);

        // Reset in the middle of a burst.
        s_if.arid[1*SIW +: SIW] = 6'd4;
        s_if.arlen[1*8 +: 8]    = 8'd3;
        s_if.arvalid[1]         = 1'b1;
        tick();
        s_if.arvalid[1] = 1'b0;
        m_if.arready    = 1'b1;
        tick();
        m_if.arready   = 1'b0;
        m_if.rvalid    = 1'b1;
        m_if.rid       = {2'd1, 6'd4};
        s_if.rready[1] = 1'b1;
        #1;
        check("pre_reset_rvalid", 64'(s_if.rvalid), 64'b0010);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // Fairness: all ports request continuously with single-beat bursts.
        for (int p = 0; p < NP; p++) begin
            s_if.arid[p*SIW +: SIW] = SIW'(10 + p);
            s_if.arlen[p*8 +: 8]    = 8'd0;
            grants[p]               = 0;
        end
        s_if.arvalid = '1;
        s_if.rready  = '1;
        for (int k = 0; k < 2 * NP; k++) begin
            int e;
            e = k % NP;
            #1;
            check("fair_arready", 64'(s_if.arready), 64'(1 << e));
            tick();
            #1;
            check("fair_grant", 64'(grant_idx), 64'(e));
            check("fair_arid", 64'(m_if.arid), 64'({IXW'(e), SIW'(10 + e)}));
            check("busy_arready_low", 64'(s_if.arready), 64'd0);
            m_if.arready = 1'b1;
            tick();
            m_if.arready = 1'b0;
            m_if.rvalid  = 1'b1;
            m_if.rlast   = 1'b1;
            m_if.rid     = {IXW'(e), SIW'(10 + e)};
            #1;
            check("fair_rvalid", 64'(s_if.rvalid), 64'(1 << e));
            if (s_if.rvalid[e]) grants[e]++;
            tick();
            m_if.rvalid = 1'b0;
            m_if.rlast  = 1'b0;
        end
        for (int p = 0; p < NP; p++) check("fair_share", 64'(grants[p]), 64'd2);
        check("fair_perr", 64'(proto_err), 64'd0);
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
